// File: rtl/key_expansion_pkg.sv
// AES shared constants and helpers.
// Used by the key schedule and cipher round stages.
package key_expansion_pkg;

  localparam int NR  = 10;
  localparam int NB  = 4;
  localparam int KW  = 128;
  localparam int EKW = KW * (NR + 1);

  typedef enum logic [1:0] {
    IDLE,
    EXPAND,
    DONE
  } ks_state_e;

  function automatic logic [7:0] rcon(
    input logic [3:0] r
  );
    logic [7:0] v;
    unique case (r)
      4'd1:    v = 8'h01;
      4'd2:    v = 8'h02;
      4'd3:    v = 8'h04;
      4'd4:    v = 8'h08;
      4'd5:    v = 8'h10;
      4'd6:    v = 8'h20;
      4'd7:    v = 8'h40;
      4'd8:    v = 8'h80;
      4'd9:    v = 8'h1b;
      4'd10:   v = 8'h36;
      default: v = 8'h00;
    endcase
    return v;
  endfunction

  // MSB bit offset of round key r in the packed expanded key
  function automatic logic [10:0] slot_msb(
    input logic [3:0] r
  );
    return 11'd1407 - {r, 7'b0};
  endfunction

endpackage

// File: rtl/key_expansion_sbox.sv
// AES forward S-box, 8-bit combinational lookup.
// Shared by the key schedule and the SubBytes stage.
module aes_sbox (
  input  logic [7:0] a,
  output logic [7:0] y
);

  localparam logic [2047:0] SBOX = {
    128'h637c777bf26b6fc53001672bfed7ab76,
    128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115,
    128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84,
    128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8,
    128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973,
    128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479,
    128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
    128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df,
    128'h8ca1890dbfe6426841992d0fb054bb16
  };

  logic [10:0] msb;

  // Entry 0 sits in the top byte of the table
  always_comb begin
    msb = 11'd2047 - {a, 3'b0};
    y   = SBOX[msb -: 8];
  end

endmodule

// File: rtl/key_expansion.sv
// Iterative AES-128 key schedule.
// One round key per clock into a held 1408-bit register.
module key_expansion
  import key_expansion_pkg::*;
(
  input  logic           clk,
  input  logic           rst,
  input  logic           start,
  input  logic [KW-1:0]  key_in,
  output logic [EKW-1:0] key,
  output logic           busy,
  output logic           finish
);

  ks_state_e   state;
  logic [3:0]  round;
  logic [3:0]  pidx;
  logic [KW-1:0] prev;
  logic [31:0] w0, w1, w2, w3;
  logic [31:0] rot, sub, t;
  logic [KW-1:0] nk;

  // Previous slot words and the next round key
  always_comb begin
    pidx = (round == 4'd0) ? 4'd0 : round - 4'd1;
    prev = key[slot_msb(pidx) -: KW];
    w0   = prev[127:96];
    w1   = prev[95:64];
    w2   = prev[63:32];
    w3   = prev[31:0];
    rot  = {w3[23:0], w3[31:24]};
    t    = sub ^ {rcon(round), 24'h0};
    nk[127:96] = w0 ^ t;
    nk[95:64]  = nk[127:96] ^ w1;
    nk[63:32]  = nk[95:64] ^ w2;
    nk[31:0]   = nk[63:32] ^ w3;
  end

  for (genvar i = 0; i < NB; i++) begin : g_sub
    aes_sbox u_sbox (
      .a (rot[8*i +: 8]),
      .y (sub[8*i +: 8])
    );
  end

  // Control FSM and expanded key register
  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      round  <= 4'd0;
      key    <= '0;
      busy   <= 1'b0;
      finish <= 1'b0;
    end else begin
      unique case (state)
        IDLE, DONE: begin
          if (start) begin
            key[EKW-1 -: KW] <= key_in;
            round  <= 4'd1;
            busy   <= 1'b1;
            finish <= 1'b0;
            state  <= EXPAND;
          end
        end
        EXPAND: begin
          key[slot_msb(round) -: KW] <= nk;
          if (round == 4'(NR)) begin
            busy   <= 1'b0;
            finish <= 1'b1;
            state  <= DONE;
          end else begin
            round <= round + 4'd1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_key_expansion.sv
// Directed and random checks of the AES-128 key schedule
// against a GF(2^8)-derived reference model.
module tb_key_expansion;

  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic [127:0]  key_in;
  logic [1407:0] key;
  logic          busy;
  logic          finish;

  int total = 0;
  int bad   = 0;

  logic [7:0] sb [256];

  localparam logic [127:0] FIPS_K  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] FIPS_S1 = 128'ha0fafe1788542cb123a339392a6c7605;
  localparam logic [127:0] FIPS_SA = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;
  localparam logic [127:0] ZERO_S1 = 128'h62636363626363636263636362636363;
  localparam logic [127:0] ZERO_SA = 128'hb4ef5bcb3e92e21123e951cf6f8f188e;

  key_expansion dut (
    .clk    (clk),
    .rst    (rst),
    .start  (start),
    .key_in (key_in),
    .key    (key),
    .busy   (busy),
    .finish (finish)
  );

  always #5 clk = ~clk;

  function automatic logic [7:0] xt(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p = 8'h00;
    logic [7:0] x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p ^= x;
      x = xt(x);
    end
    return p;
  endfunction

  function automatic logic [7:0] rotl(input logic [7:0] b, input int n);
    logic [15:0] d = {b, b};
    return d[15-n -: 8];
  endfunction

  function automatic logic [7:0] sbox_ref(input logic [7:0] a);
    logic [7:0] inv = 8'h00;
    for (int b = 1; b < 256; b++)
      if (gmul(a, 8'(b)) == 8'h01) inv = 8'(b);
    return inv ^ rotl(inv, 1) ^ rotl(inv, 2) ^ rotl(inv, 3)
         ^ rotl(inv, 4) ^ 8'h63;
  endfunction

  function automatic logic [31:0] subw(input logic [31:0] w);
    return {sb[w[31:24]], sb[w[23:16]], sb[w[15:8]], sb[w[7:0]]};
  endfunction

  function automatic logic [1407:0] expand(input logic [127:0] k);
    logic [31:0]   w [44];
    logic [31:0]   tmp;
    logic [7:0]    rc = 8'h01;
    logic [1407:0] o;
    for (int i = 0; i < 4; i++) w[i] = k[127-32*i -: 32];
    for (int i = 4; i < 44; i++) begin
      tmp = w[i-1];
      if (i % 4 == 0) begin
        tmp = subw({tmp[23:0], tmp[31:24]}) ^ {rc, 24'h0};
        rc  = xt(rc);
      end
      w[i] = w[i-4] ^ tmp;
    end
    for (int i = 0; i < 44; i++) o[1407-32*i -: 32] = w[i];
    return o;
  endfunction

  function automatic logic [127:0] slot(input logic [1407:0] k, input int r);
    return k[1407-128*r -: 128];
  endfunction

  task automatic chk(input string tag, input logic [127:0] obs,
                     input logic [127:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s obs=%h exp=%h", tag, obs, exp);
    end
  endtask

  task automatic chk_all(input string tag, input logic [1407:0] exp);
    for (int r = 0; r <= 10; r++)
      chk($sformatf("%s_slot%0d", tag, r), slot(key, r), slot(exp, r));
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Start pulse then wait through the 10-cycle expansion
  task automatic run(input string tag, input logic [127:0] k);
    key_in = k;
    start  = 1'b1;
    tick();
    start  = 1'b0;
    key_in = $urandom();
    chk({tag, "_e0"}, {126'd0, busy, finish}, 128'd2);
    for (int i = 1; i <= 10; i++) begin
      tick();
      if (i < 10)
        chk($sformatf("%s_c%0d", tag, i), {126'd0, busy, finish}, 128'd2);
      else
        chk({tag, "_done"}, {126'd0, busy, finish}, 128'd1);
    end
  endtask

  logic [1407:0] held;
  logic [127:0]  rk;

  initial begin
    for (int i = 0; i < 256; i++) sb[i] = sbox_ref(8'(i));

    rst = 1'b1; start = 1'b0; key_in = '0;
    tick(); tick();
    chk("rst_busy",   {127'd0, busy},   128'd0);
    chk("rst_finish", {127'd0, finish}, 128'd0);
    chk_all("rst_key", '0);
    rst = 1'b0;
    tick();

    run("fips", FIPS_K);
    chk("fips_s0",  slot(key, 0),  FIPS_K);
    chk("fips_s1",  slot(key, 1),  FIPS_S1);
    chk("fips_s10", slot(key, 10), FIPS_SA);
    chk_all("fips_model", expand(FIPS_K));

    held = key;
    for (int i = 0; i < 20; i++) begin
      key_in = {$urandom(), $urandom(), $urandom(), $urandom()};
      tick();
      chk($sformatf("hold_s10_%0d", i), slot(key, 10), slot(held, 10));
      chk($sformatf("hold_s0_%0d", i), slot(key, 0), slot(held, 0));
      chk($sformatf("hold_fin_%0d", i), {127'd0, finish}, 128'd1);
    end

    run("zero", 128'd0);
    chk("zero_s1",  slot(key, 1),  ZERO_S1);
    chk("zero_s10", slot(key, 10), ZERO_SA);
    chk_all("zero_model", expand('0));

    key_in = FIPS_K;
    start  = 1'b1;
    tick();
    start  = 1'b0;
    for (int i = 1; i <= 10; i++) begin
      if (i == 4) begin
        key_in = '0;
        start  = 1'b1;
      end
      tick();
      start = 1'b0;
      if (i < 10)
        chk($sformatf("ign_c%0d", i), {126'd0, busy, finish}, 128'd2);
    end
    chk("ign_done", {126'd0, busy, finish}, 128'd1);
    chk_all("ign_model", expand(FIPS_K));
    tick(); tick();
    chk("ign_norestart", {126'd0, busy, finish}, 128'd1);
    chk("ign_s10", slot(key, 10), FIPS_SA);

    rk = {$urandom(), $urandom(), $urandom(), $urandom()};
    key_in = rk;
    start  = 1'b1;
    tick();
    start  = 1'b0;
    for (int i = 0; i < 4; i++) tick();
    rst = 1'b1;
    tick();
    chk("mid_busy",   {127'd0, busy},   128'd0);
    chk("mid_finish", {127'd0, finish}, 128'd0);
    chk_all("mid_key", '0);
    start  = 1'b1;
    key_in = rk;
    tick();
    rst   = 1'b0;
    start = 1'b0;
    chk("rstwin_busy", {127'd0, busy}, 128'd0);
    chk("rstwin_s0",   slot(key, 0),   128'd0);
    tick(); tick();
    chk("idle_busy",   {127'd0, busy},   128'd0);
    chk("idle_finish", {127'd0, finish}, 128'd0);

    for (int n = 0; n < 6; n++) begin
      rk = {$urandom(), $urandom(), $urandom(), $urandom()};
      run($sformatf("rnd%0d", n), rk);
      chk_all($sformatf("rnd%0d", n), expand(rk));
      for (int j = 0; j < int'($urandom_range(0, 3)); j++) tick();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/key_expansion.md
Name: key_expansion

Overview:
- Iterative AES-128 key schedule. Expands a 128-bit cipher key into the 1408-bit expanded key (11 round keys) consumed by the round-key-addition stage.
- Sits directly upstream of that stage and drives its key input. Rounds 0..10 are packed MSB-first: round r occupies bits [1407-128*r -: 128].
- Computes one round key per clock. The expanded key is registered and held stable until the next start or reset.

Parameters:
- NR, 10, number of expansion rounds (AES-128). Fixed; any other value is unsupported.
- KW, 128, cipher key / round key width in bits.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  reset. Synchronous, active-high.
- start  input  1  request expansion of key_in. Sampled on the rising edge.
- key_in  input  128  cipher key, word w0 in bits [127:96].
- key  output  1408  expanded key. Round 0 in [1407:1280], round 10 in [127:0].
- busy  output  1  high while expansion is in progress.
- finish  output  1  high when key holds a complete valid expansion.

Behaviour:
- Single clock domain, clk only. Reset is synchronous and active-high on rst.
- Reset values: key=0, finish=0, busy=0, state=IDLE, round counter=0. Reset overrides start on the same edge.
- Reset mid-expansion aborts the expansion and clears key.
- FSM states: IDLE, EXPAND, DONE.
- IDLE, start=1 at edge E0:
  - key[1407:1280] <= key_in; round <= 1.
  - busy <= 1; finish <= 0; go to EXPAND.
  - key_in is captured only at E0; later changes are ignored.
- EXPAND, each edge Er (r=1..10): writes round key r into slot r, from the previous round words w0..w3 (slot r-1):
  - t = SubWord(RotWord(w3)) ^ {Rcon[r], 24'h0}
  - n0 = w0^t; n1 = n0^w1; n2 = n1^w2; n3 = n2^w3.
  - Slot r <= {n0,n1,n2,n3}; round <= round+1.
- Terminal edge E10: go to DONE; busy <= 0; finish <= 1. Latency is 10 cycles from the start edge to finish visible.
- DONE: key and finish are held. start=1 behaves exactly as in IDLE: the new key is captured, finish drops at that edge, expansion restarts.
- start while in EXPAND is ignored; the expansion in progress completes unaltered.
- Slots not yet written during EXPAND keep their prior contents. Downstream must qualify key with finish.
- RotWord: {b1,b2,b3,b0} of word {b0,b1,b2,b3}. SubWord: AES S-box applied to each byte.
- Rcon[1..10] = 01,02,04,08,10,20,40,80,1b,36.
- The round counter is 4 bits and never wraps past 10. Index 0 and indices 11..15 are unreachable; Rcon returns 0 for them.
- Single registered datapath. No combinational path from start or key_in to the outputs.

Decomposition:
- Shared package/include, reused by the cipher round stages:
  - AES constants NR=10, NB=4, KW=128.
  - Rcon table as a function.
  - Round-key slice helper: index r -> bit offset 1407-128*r.
- Sub-module aes_sbox: combinational 8-bit in / 8-bit out forward S-box ROM.
  - Four instances form SubWord.
  - The same module is reused by the SubBytes stage.

Test Plan:
- FIPS-197 App. A.1:
  - Stimulus: rst, then start with key_in=2b7e151628aed2a6abf7158809cf4f3c.
  - finish rises exactly 10 cycles after the start edge; busy is high for those 10 cycles.
  - Slot 1 = a0fafe1788542cb123a339392a6c7605; slot 10 = d014f9a8c9ee2589e13f0cc8b6630ca6; slot 0 = key_in.
- All-zero key:
  - Slot 1 = 62636363626363636263636362636363.
  - Slot 10 = b4ef5bcb3e92e21123e951cf6f8f188e.
- Start during EXPAND:
  - Start with the FIPS key, then pulse start with the zero key at cycle 4.
  - The FIPS expansion completes; slot 10 = d014f9a8...; no restart occurs.
- Restart from DONE:
  - After the FIPS expansion, start with the zero key.
  - finish=0 on the next cycle; after 10 cycles slot 10 = b4ef5bcb...
- Reset mid-operation:
  - Assert rst at cycle 5 of an expansion.
  - Next cycle: key=0, busy=0, finish=0.
  - start with rst high in the same cycle: rst wins, state stays IDLE.
- Hold stability:
  - After finish, toggle key_in for 20 cycles with start low.
  - key and finish are unchanged throughout.
